// File: rtl/tx_sequencer.sv
// tx_sequencer: PPS-aligned Costas/PSK transmit sequencer with MCU triggers.
// Define PPS_TIMEOUT_EN to enable the ARMED-state pps watchdog (pps_err).
module tx_sequencer #(
  parameter int COSTAS_SYMBOLS     = 12,
  parameter int COSTAS_SYM_CYCLES  = 100000,
  parameter int PSK_SYMBOLS        = 250,
  parameter int PSK_SIGNAL_RATE_HZ = 125,
  parameter int TRIG_CYCLES        = 16,
  parameter int PPS_TIMEOUT_CYCLES = 12_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pps,
  input  logic        costas_txrq,
  input  logic        psk_txrq,
  output logic        mcu_costas_trigger,
  output logic        mcu_psk_trigger,
  output logic        fq_ud,
  output logic        busy,
  output logic [15:0] sym_idx,
  output logic        pps_err
);

  localparam int C_PER = COSTAS_SYM_CYCLES;
  localparam int P_PER = 10_000_000 / PSK_SIGNAL_RATE_HZ;
  localparam int M_PER = (C_PER > P_PER) ? C_PER : P_PER;
  localparam int CW = (M_PER > 1) ? $clog2(M_PER) : 1;
  localparam int TW = (TRIG_CYCLES > 0) ? $clog2(TRIG_CYCLES + 1) : 1;
  localparam int AW = (PPS_TIMEOUT_CYCLES > 1) ?
                      $clog2(PPS_TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] C_END = CW'(C_PER - 1);
  localparam logic [CW-1:0] P_END = CW'(P_PER - 1);
  localparam logic [15:0] C_LAST = 16'(COSTAS_SYMBOLS - 1);
  localparam logic [15:0] P_LAST = 16'(PSK_SYMBOLS - 1);
  localparam logic [TW-1:0] TRIG_LD = TW'(TRIG_CYCLES);
  localparam logic [AW-1:0] A_END = AW'(PPS_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, ARMED, COSTAS, PSK
  } state_t;

  logic [2:0] raw, s1, s2, hist, lo_seen, rise;
  logic [1:0] vld;
  logic       pps_e, c_e, p_e;

  state_t        state, state_n;
  logic          cpend, cpend_n, ppend, ppend_n;
  logic [CW-1:0] cnt, cnt_n, end_cnt;
  logic [15:0]   sym, sym_n, last_sym;
  logic [TW-1:0] trig, trig_n;
  logic [AW-1:0] arm_cnt, arm_n;
  logic          err_q, err_n;
  logic          run;

  assign raw = {psk_txrq, costas_txrq, pps};
  // lo_seen gates out levels already high when reset released
  assign rise  = s2 & ~hist & lo_seen;
  assign pps_e = rise[0];
  assign c_e   = rise[1];
  assign p_e   = rise[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      hist    <= '0;
      vld     <= '0;
      lo_seen <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      hist    <= s2;
      vld     <= {vld[0], 1'b1};
      lo_seen <= lo_seen | ({3{vld[1]}} & ~s2);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cpend   <= 1'b0;
      ppend   <= 1'b0;
      cnt     <= '0;
      sym     <= '0;
      trig    <= '0;
      arm_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cpend   <= cpend_n;
      ppend   <= ppend_n;
      cnt     <= cnt_n;
      sym     <= sym_n;
      trig    <= trig_n;
      arm_cnt <= arm_n;
      err_q   <= err_n;
    end
  end

  assign end_cnt  = (state == PSK) ? P_END : C_END;
  assign last_sym = (state == PSK) ? P_LAST : C_LAST;

  always_comb begin
    state_n = state;
    cpend_n = cpend;
    ppend_n = ppend;
    cnt_n   = cnt;
    sym_n   = sym;
    trig_n  = trig;
    arm_n   = '0;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        if (cpend || ppend) state_n = ARMED;
      end
      ARMED: begin
        arm_n = (arm_cnt == A_END) ? arm_cnt : arm_cnt + 1'b1;
        if (pps_e && cpend) begin
          state_n = COSTAS;
          cpend_n = 1'b0;
          cnt_n   = '0;
          sym_n   = '0;
          trig_n  = TRIG_LD;
        end else if (pps_e && ppend) begin
          state_n = PSK;
          ppend_n = 1'b0;
          cnt_n   = '0;
          sym_n   = '0;
          trig_n  = TRIG_LD;
        end else if (!cpend && !ppend) begin
          state_n = IDLE;
`ifdef PPS_TIMEOUT_EN
        end else if (arm_cnt == A_END) begin
          state_n = IDLE;
          cpend_n = 1'b0;
          ppend_n = 1'b0;
          err_n   = 1'b1;
`endif
        end
      end
      COSTAS, PSK: begin
        if (trig != '0) trig_n = trig - 1'b1;
        if (cnt == end_cnt) begin
          cnt_n = '0;
          if (sym == last_sym)
            state_n = (cpend || ppend) ? ARMED : IDLE;
          else if (sym != 16'hFFFF)
            sym_n = sym + 16'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
    // a fresh request wins over a same-cycle start clear
    if (c_e) cpend_n = 1'b1;
    if (p_e) ppend_n = 1'b1;
  end

  assign run = (state == COSTAS) || (state == PSK);
  assign busy = (state != IDLE);
  assign fq_ud = run && (cnt == '0);
  assign mcu_costas_trigger = (state == COSTAS) && (trig != '0);
  assign mcu_psk_trigger = (state == PSK) && (trig != '0);
  assign sym_idx = sym;
  assign pps_err = err_q;

endmodule
